sram_mem_controller: RTL and testbench
======================================

# sram_mem_controller

Memory-stage data-memory controller for the ARM pipeline. It sits directly downstream of the CPU's MEM stage. It converts one 32-bit word load or store into two sequential 16-bit accesses on an external single-port SRAM. While an access is in flight it drops `ready`, which the pipeline uses to freeze every stage.

## Interface
Parameters:
- `ADDR_BASE`, default 1024: byte address of data-memory word 0; subtracted from `address` before translation.
- `WAIT_CYCLES`, default 2: cycles each 16-bit half-access holds address, data and strobes. Legal range is 1..7.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wrEn`  in  1  store request from the MEM stage.
- `rdEn`  in  1  load request from the MEM stage.
- `address`  in  32  byte address; bits [1:0] ignored.
- `writeData`  in  32  store data.
- `readData`  out  32  load result; registered.
- `ready`  out  1  1 = pipeline may advance; 0 = freeze.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_out`  out  16  write data toward the SRAM.
- `sram_dq_oe`  out  1  1 = drive `sram_dq_out` onto the SRAM bus.
- `sram_dq_in`  in  16  read data from the SRAM.
- `sram_we_n`  out  1  SRAM write enable, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE. A 3-bit phase counter `cnt` counts 0..WAIT_CYCLES-1.
- Request = `wrEn | rdEn`. If both are asserted, the access is a write and `rdEn` is ignored.
- **IDLE**
  - With a request: latch the word index `(address - ADDR_BASE) >> 2` (17 bits), latch `writeData`, and latch the op (write/read). Then go to LOW with `cnt` = 0.
  - Without a request: stay in IDLE.
- **LOW**
  - `sram_addr` = {idx, 1'b0}.
  - Write: `sram_dq_out` = data[15:0], `sram_dq_oe` = 1, `sram_we_n` = 0.
  - Read: `sram_dq_oe` = 0, `sram_we_n` = 1. On the edge ending the last phase cycle (`cnt` = WAIT_CYCLES-1), capture `sram_dq_in` into an internal `lo` register.
  - When `cnt` = WAIT_CYCLES-1: go to HIGH and set `cnt` = 0. Otherwise increment `cnt`.
- **HIGH**
  - Same as LOW, but `sram_addr` = {idx, 1'b1} and write data is data[31:16].
  - Read, on the final-cycle edge: `readData` <= {`sram_dq_in`, `lo`}. `readData` is written only here.
  - Last cycle: go to DONE.
- **DONE**
  - Strobes are idle.
  - Unconditionally go to IDLE.
- `ready` (combinational):
  - 1 in DONE.
  - 1 in IDLE with no request.
  - 0 otherwise, including IDLE with a request, so the pipeline freezes in the same cycle the request appears.
- Strobes outside LOW/HIGH: `sram_we_n` = 1, `sram_dq_oe` = 0. `sram_addr` and `sram_dq_out` hold their last values.
- Address arithmetic:
  - 32-bit subtraction, truncated to bits [18:2].
  - Addresses below `ADDR_BASE` wrap modulo 2^17 words; no error is flagged.
- Inputs are sampled only in IDLE. Changes to `address`, `writeData`, `wrEn` or `rdEn` during LOW/HIGH/DONE have no effect, and an access in flight always completes.
- `readData` holds its value across writes and idle periods.

## Timing
- Reset (the cycle after `rst` is sampled high):
  - state = IDLE, `cnt` = 0.
  - `readData` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
  - `sram_dq_oe` = 0, `sram_we_n` = 1.
  - `ready` = 1 when no request is present.
- Reset mid-access aborts the access immediately. `readData` is cleared, and a write may leave the SRAM with only its low half written.
- Latency, with the request first seen in IDLE at cycle 0:
  - LOW: cycles 1..W.
  - HIGH: cycles W+1..2W.
  - DONE: cycle 2W+1; `ready` = 1 here.
  - Default W=2: `ready` is low for cycles 0-4 and high in cycle 5, a 6-cycle access.
- `readData` is valid from cycle 2W+1 (DONE) onward. The consuming stage samples it at the end of DONE.
- Back-to-back: after DONE the pipeline advances. A new request at cycle 2W+2 is seen in IDLE, giving one IDLE cycle with `ready` = 0 before the next LOW.
- `sram_we_n` is low for exactly W consecutive cycles per half. Address and data are stable through the whole half-phase, including the cycle when `sram_we_n` deasserts.

## Test plan
- Reset with `rdEn` = `wrEn` = 0:
  - `ready` = 1, `sram_we_n` = 1, `sram_dq_oe` = 0, `readData` = 0.
  - Stays this way for 10 cycles.
- Store 0xDEADBEEF to address 1028, W=2:
  - SRAM model sees half-address 2 = 0xBEEF, then half-address 3 = 0xDEAD.
  - `sram_we_n` is low for 2 cycles per half.
  - `ready` is low for 5 cycles, then high 1 cycle.
- Load from 1028 after that store:
  - `readData` = 0xDEADBEEF in the DONE cycle (6th cycle of the request).
  - `sram_dq_oe` = 0 throughout.
- `rdEn` = `wrEn` = 1, address 1032, data 0x12345678:
  - Write performed: half-address 4 = 0x5678, half-address 5 = 0x1234.
  - `readData` unchanged.
- Change `address`/`writeData` during HIGH of a store:
  - SRAM contents reflect only the originally latched values.
- `rst` asserted in the 2nd LOW cycle of a load:
  - Next cycle: state IDLE, `readData` = 0, `ready` = !request, `sram_we_n` = 1.

Source files
------------

// File: rtl/sram_mem_controller.sv
// Data-memory controller: splits each 32-bit load/store into two 16-bit
// accesses on a single-port SRAM, holding ready low while in flight.
module sram_mem_controller #(
   parameter int ADDR_BASE   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrEn,
   input  logic        rdEn,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_we_n
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam logic [2:0] LAST = 3'(WAIT_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg, cnt_next;
   logic [16:0] idx_reg;
   logic [31:0] data_reg;
   logic        wr_reg;
   logic [15:0] lo_reg;
   logic [31:0] read_data_reg;
   logic [17:0] addr_reg;
   logic [15:0] dq_reg;

   logic        req;
   logic        last;
   logic [16:0] idx_calc;

   assign req      = wrEn | rdEn;
   assign last     = (cnt_reg == LAST);
   // Below-base addresses simply wrap within the 17-bit word index space
   assign idx_calc = 17'((address - 32'(ADDR_BASE)) >> 2);

   assign readData    = read_data_reg;
   assign sram_addr   = addr_reg;
   assign sram_dq_out = dq_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      ready      = 1'b0;
      sram_we_n  = 1'b1;
      sram_dq_oe = 1'b0;
      case (state_reg)
         IDLE: begin
            ready = ~req;
            if (req) begin
               state_next = LOW;
               cnt_next   = 3'd0;
            end
         end
         LOW, HIGH: begin
            sram_we_n  = ~wr_reg;
            sram_dq_oe = wr_reg;
            if (last) begin
               cnt_next   = 3'd0;
               state_next = (state_reg == LOW) ? HIGH : DONE;
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         DONE: begin
            ready      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 3'd0;
         idx_reg       <= '0;
         data_reg      <= '0;
         wr_reg        <= 1'b0;
         lo_reg        <= '0;
         read_data_reg <= '0;
         addr_reg      <= '0;
         dq_reg        <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         case (state_reg)
            IDLE: if (req) begin
               idx_reg  <= idx_calc;
               data_reg <= writeData;
               wr_reg   <= wrEn;
               addr_reg <= {idx_calc, 1'b0};
               if (wrEn) dq_reg <= writeData[15:0];
            end
            // Address/data switch to the high half on the same edge that enters HIGH
            LOW: if (last) begin
               if (!wr_reg) lo_reg <= sram_dq_in;
               addr_reg <= {idx_reg, 1'b1};
               if (wr_reg) dq_reg <= data_reg[31:16];
            end
            HIGH: if (last && !wr_reg) read_data_reg <= {sram_dq_in, lo_reg};
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench: directed cases plus random loads/stores against a
// word-level reference memory and a behavioural SRAM model.
module tb_sram_mem_controller;

   localparam int W    = 2;
   localparam int BASE = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrEn, rdEn;
   logic [31:0] address, writeData;
   logic [31:0] readData;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] sram_mem [0:262143];
   logic [31:0] ref_mem [logic [16:0]];
   logic [31:0] written_q [$];
   logic [31:0] last_read;

   sram_mem_controller #(.ADDR_BASE(BASE), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .address(address),
      .writeData(writeData), .readData(readData), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
   assign sram_dq_in = sram_mem[sram_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full access starting in IDLE; checks timing, strobes, SRAM and readData
   task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data, input bit scramble);
      logic [16:0] idx;
      bit          is_wr;
      int          we_low, oe_seen;
      logic [31:0] exp_rd;
      idx   = 17'((addr - 32'(BASE)) >> 2);
      is_wr = wr;
      we_low  = 0;
      oe_seen = 0;
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      wrEn = wr; rdEn = rd; address = addr; writeData = data;
      #1 check("req_ready_c0", 32'(ready), 32'd0);
      for (int k = 1; k <= 2*W + 1; k++) begin
         @(negedge clk);
         if (!sram_we_n) we_low++;
         if (sram_dq_oe) oe_seen++;
         if (k == 1)     check("addr_low", 32'(sram_addr), 32'({idx, 1'b0}));
         if (k == W + 1) check("addr_high", 32'(sram_addr), 32'({idx, 1'b1}));
         if (k == W + 1 && scramble) begin
            address = $urandom; writeData = $urandom; wrEn = 1'b1; rdEn = 1'b1;
         end
         if (k == 2*W) check("ready_busy_end", 32'(ready), 32'd0);
      end
      check("ready_done", 32'(ready), 32'd1);
      exp_rd = is_wr ? last_read : (ref_mem.exists(idx) ? ref_mem[idx] : 32'd0);
      check("readData_done", readData, exp_rd);
      check("we_low_cycles", 32'(we_low), is_wr ? 32'(2*W) : 32'd0);
      check("oe_cycles", 32'(oe_seen), is_wr ? 32'(2*W) : 32'd0);
      if (is_wr) begin
         ref_mem[idx] = data;
         written_q.push_back(addr);
         check("sram_lo", 32'(sram_mem[{idx, 1'b0}]), 32'(data[15:0]));
         check("sram_hi", 32'(sram_mem[{idx, 1'b1}]), 32'(data[31:16]));
      end else begin
         last_read = exp_rd;
      end
      $display("access wr=%0b rd=%0b addr=%h data=%h idx=%h readData=%h",
               wr, rd, addr, data, idx, readData);
      wrEn = 1'b0; rdEn = 1'b0;
   endtask

   initial begin
      logic [31:0] a, d;
      bit          w, r;
      rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; address = '0; writeData = '0;
      last_read = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0 || i == 9) begin
            check("rst_ready", 32'(ready), 32'd1);
            check("rst_we_n", 32'(sram_we_n), 32'd1);
            check("rst_oe", 32'(sram_dq_oe), 32'd0);
            check("rst_readData", readData, 32'd0);
            check("rst_sram_addr", 32'(sram_addr), 32'd0);
         end
      end

      access(1, 0, 32'd1028, 32'hDEADBEEF, 0);
      check("store_half2", 32'(sram_mem[2]), 32'h0000BEEF);
      check("store_half3", 32'(sram_mem[3]), 32'h0000DEAD);
      access(0, 1, 32'd1028, 32'h0, 0);
      check("load_dead", readData, 32'hDEADBEEF);
      access(1, 1, 32'd1032, 32'h12345678, 0);
      check("both_half4", 32'(sram_mem[4]), 32'h00005678);
      check("both_half5", 32'(sram_mem[5]), 32'h00001234);
      check("both_readData", readData, 32'hDEADBEEF);
      access(1, 0, 32'd1036, 32'hCAFEF00D, 1);
      access(1, 0, 32'd1020, 32'hA5A55A5A, 0);
      check("wrap_lo", 32'(sram_mem[18'h3FFFE]), 32'h00005A5A);
      access(0, 1, 32'd1020, 32'h0, 0);

      for (int n = 0; n < 24; n++) begin
         w = ($urandom_range(0, 1) == 1);
         r = w ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (w) begin
            a = ($urandom_range(0, 7) == 0) ? 32'(BASE - 4*$urandom_range(1, 4))
                                            : 32'(BASE + 4*$urandom_range(0, 255));
            a = a | 32'($urandom_range(0, 3));
         end else begin
            a = written_q[$urandom_range(0, written_q.size() - 1)];
         end
         d = $urandom;
         access(w, r, a, d, ($urandom_range(0, 3) == 0));
      end

      // Reset landing in the second LOW cycle of a load
      access(0, 1, 32'd1028, 32'h0, 0);
      @(negedge clk);
      rdEn = 1'b1; address = 32'd1032;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_readData", readData, last_read);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_readData", readData, 32'd0);
      check("mid_rst_we_n", 32'(sram_we_n), 32'd1);
      check("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
      check("mid_rst_ready", 32'(ready), 32'd0);
      rst = 1'b0; rdEn = 1'b0;
      #1 check("post_rst_ready", 32'(ready), 32'd1);
      $display("reset mid-access readData=%h ready=%0b", readData, ready);
      last_read = '0;
      access(0, 1, 32'd1032, 32'h0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
